data_mem_ctrl: RTL and testbench

Data-memory access controller for the MEM stage of the 5-stage pipeline. It takes the MEM-stage load/store request and runs a req/ack handshake with the multi-cycle backing memory. It drives MemReady, the global "memory not busy" signal that the hazard logic uses to freeze the pipeline. It returns load data to the MEM/WB register and flags misaligned or timed-out accesses.

---
 rtl/data_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store controller bridging the pipeline to a multi-cycle backing memory.
// Latency: request registered one edge after the MEM cycle; load data valid when MemReady rises (2 cycles minimum).
// Backpressure: MemReady drops combinationally on a new access and stays low until ack or timeout abort.
module data_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemReady,
    output logic              MemErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter is one bit wider than needed so it never wraps on the terminating edge.
    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] waitCnt;
    logic             timeoutFlag;

    logic             acc;
    logic             mis;
    logic             startAcc;
    logic             ackDone;
    logic             timeoutHit;

    // A store and a load in the same cycle is resolved as a store further down;
    // misalignment only matters when some access is actually requested.
    assign acc = MemReadM | MemWriteM;
    assign mis = acc & (ALUOutM[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and pipeline-facing status; reset forces the pipeline free and fault-free.
    always_comb begin
        nextState  = state;
        startAcc   = 1'b0;
        ackDone    = 1'b0;
        timeoutHit = 1'b0;
        MemReady   = 1'b1;
        MemErr     = 1'b0;
        case (state)
            IDLE: begin
                if (mis) begin
                    // Faulting access is reported and dropped; pipeline keeps moving.
                    MemErr = 1'b1;
                end else if (acc) begin
                    // Stall in the same cycle so the MEM instruction is held.
                    MemReady  = 1'b0;
                    startAcc  = 1'b1;
                    nextState = BUSY;
                end
            end
            BUSY: begin
                MemReady = 1'b0;
                // Ack takes priority over a timeout reached in the same cycle.
                if (mem_ack) begin
                    ackDone   = 1'b1;
                    nextState = DONE;
                end else if (waitCnt == LAST_CNT) begin
                    timeoutHit = 1'b1;
                    nextState  = DONE;
                end
            end
            DONE: begin
                // One release cycle; MEM inputs are ignored so the instruction is not re-issued.
                MemErr    = timeoutFlag;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (rst) begin
            MemReady   = 1'b1;
            MemErr     = 1'b0;
            startAcc   = 1'b0;
            ackDone    = 1'b0;
            timeoutHit = 1'b0;
            nextState  = IDLE;
        end
    end

    // Backing-memory request: captured at start and held stable until ack or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (startAcc) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
            mem_wdata <= WriteDataM;
        end else if (ackDone || timeoutHit) begin
            mem_req   <= 1'b0;
        end
    end

    // Wait-cycle counter: zeroed on entry to BUSY, counts every BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (startAcc) begin
            waitCnt <= '0;
        end else if (state == BUSY) begin
            waitCnt <= waitCnt + CNT_W'(1);
        end
    end

    // Timeout flag: set on abort, reported during DONE, cleared on leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutFlag <= 1'b0;
        end else if (timeoutHit) begin
            timeoutFlag <= 1'b1;
        end else if (state == DONE) begin
            timeoutFlag <= 1'b0;
        end
    end

    // Load data: updated only by completed or aborted reads; stores leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ReadDataM <= '0;
        end else if (ackDone && !mem_we) begin
            ReadDataM <= mem_rdata;
        end else if (timeoutHit && !mem_we) begin
            ReadDataM <= '0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized checks of data_mem_ctrl against a transaction-level model.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 2 units after it.
// Backpressure: the bench plays the pipeline (holds the request while MemReady=0) and the memory (acks after N waits).
module tb_data_mem_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemReady;
    logic        MemErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] expRead = 32'h0;

    typedef struct {
        int          stall;
        int          reqCycles;
        logic        hung;
        logic        readyCycle0;
        logic        errAtReady;
        logic        reqAtReady;
        logic [31:0] rdAtReady;
        logic        stable;
        logic [31:0] addrSeen;
        logic [31:0] wdataSeen;
        logic        weSeen;
    } obs_t;

    data_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .MemReady(MemReady), .MemErr(MemErr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drop all MEM-stage requests at the next cycle.
    task automatic go_idle();
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0; mem_ack = 1'b0;
    endtask

    // Plays one MEM-stage access and a memory that acks after 'waits' BUSY cycles; records what it saw.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input logic [31:0] rdata, output obs_t o);
        logic done;
        o.stall = 0; o.reqCycles = 0; o.hung = 1'b0; o.readyCycle0 = 1'b0; o.errAtReady = 1'b0;
        o.reqAtReady = 1'b0; o.rdAtReady = 32'h0; o.stable = 1'b1; o.addrSeen = 32'h0;
        o.wdataSeen = 32'h0; o.weSeen = 1'b0;
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = wdata; mem_ack = 1'b0;
        #1;
        if (MemReady) begin
            o.readyCycle0 = 1'b1; o.errAtReady = MemErr; o.rdAtReady = ReadDataM; o.reqAtReady = mem_req;
            @(posedge clk); #1;
            MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = 32'h0;
            #1;
            if (mem_req) o.reqCycles++;
            return;
        end
        o.stall = 1;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(posedge clk); #1;
            mem_ack   = (k == waits);
            mem_rdata = (k == waits) ? rdata : $urandom;
            #1;
            if (MemReady) begin
                done = 1'b1;
                o.errAtReady = MemErr; o.rdAtReady = ReadDataM; o.reqAtReady = mem_req;
                mem_ack = 1'b0;
            end else begin
                o.stall++;
                if (mem_req) begin
                    o.reqCycles++;
                    if (k == 0) begin
                        o.addrSeen = mem_addr; o.wdataSeen = mem_wdata; o.weSeen = mem_we;
                    end else if (mem_addr !== o.addrSeen || mem_wdata !== o.wdataSeen || mem_we !== o.weSeen) begin
                        o.stable = 1'b0;
                    end
                end
            end
        end
        o.hung = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h10; WriteDataM = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (MemReady !== 1'b1) begin errors++; $display("FAIL rst_ready_forced: got %b want 1", MemReady); end
        @(posedge clk); #1; ALUOutM = 32'h12; #1;
        checks++; if (MemErr !== 1'b0) begin errors++; $display("FAIL rst_err_forced: got %b want 0", MemErr); end
        @(posedge clk); #1; rst = 1'b0; MemReadM = 1'b0; ALUOutM = 32'h0; #1;
        checks++; if (MemReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", MemReady); end
        checks++; if (MemErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", MemErr); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) begin errors++; $display("FAIL reset_memif: we=%b addr=%h wdata=%h want 0", mem_we, mem_addr, mem_wdata); end
        expRead = 32'h0;
    endtask

    task automatic test_load_wait();
        obs_t o;
        run_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3, 32'hDEAD_BEEF, o);
        go_idle();
        expRead = 32'hDEAD_BEEF;
        checks++; if (o.hung !== 1'b0) begin errors++; $display("FAIL load_hung: MemReady never rose"); end
        checks++; if (o.addrSeen !== 32'h104) begin errors++; $display("FAIL load_addr: got %h want 104", o.addrSeen); end
        checks++; if (o.weSeen !== 1'b0) begin errors++; $display("FAIL load_we: got %b want 0", o.weSeen); end
        checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL load_stable: request changed during BUSY"); end
        checks++; if (o.stall !== 5) begin errors++; $display("FAIL load_stall: got %0d want 5", o.stall); end
        checks++; if (o.rdAtReady !== expRead) begin errors++; $display("FAIL load_rdata: got %h want %h", o.rdAtReady, expRead); end
        checks++; if (o.reqCycles !== 4 || o.reqAtReady !== 1'b0) begin errors++; $display("FAIL load_req_drop: reqCycles=%0d reqAtDone=%b want 4,0", o.reqCycles, o.reqAtReady); end
        checks++; if (o.errAtReady !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", o.errAtReady); end
    endtask

    task automatic test_store();
        obs_t o;
        run_access(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 0, 32'hFFFF_0000, o);
        go_idle();
        checks++; if (o.weSeen !== 1'b1) begin errors++; $display("FAIL store_we: got %b want 1", o.weSeen); end
        checks++; if (o.wdataSeen !== 32'h1234_5678) begin errors++; $display("FAIL store_wdata: got %h want 12345678", o.wdataSeen); end
        checks++; if (o.addrSeen !== 32'h200) begin errors++; $display("FAIL store_addr: got %h want 200", o.addrSeen); end
        checks++; if (o.stall !== 2) begin errors++; $display("FAIL store_stall: got %0d want 2", o.stall); end
        checks++; if (o.rdAtReady !== expRead) begin errors++; $display("FAIL store_rdata_kept: got %h want %h", o.rdAtReady, expRead); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h5555_5555, o);
        checks++; if (o.readyCycle0 !== 1'b1 || o.errAtReady !== 1'b1) begin errors++; $display("FAIL mis_flags: ready=%b err=%b want 1,1", o.readyCycle0, o.errAtReady); end
        checks++; if (o.reqCycles !== 0 || o.reqAtReady !== 1'b0) begin errors++; $display("FAIL mis_req: reqCycles=%0d want 0", o.reqCycles); end
        checks++; if (ReadDataM !== expRead) begin errors++; $display("FAIL mis_rdata_kept: got %h want %h", ReadDataM, expRead); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1000, 32'h0, o);
        expRead = 32'h0;
        checks++; if (o.reqCycles !== TO) begin errors++; $display("FAIL to_req_cycles: got %0d want %0d", o.reqCycles, TO); end
        checks++; if (o.stall !== TO + 1) begin errors++; $display("FAIL to_stall: got %0d want %0d", o.stall, TO + 1); end
        checks++; if (o.errAtReady !== 1'b1 || o.reqAtReady !== 1'b0) begin errors++; $display("FAIL to_done: err=%b req=%b want 1,0", o.errAtReady, o.reqAtReady); end
        checks++; if (o.rdAtReady !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", o.rdAtReady); end
        // Follow-up access back-to-back after the abort.
        run_access(1'b1, 1'b0, 32'h0000_0304, 32'h0, 1, 32'hA5A5_0001, o);
        go_idle();
        expRead = 32'hA5A5_0001;
        checks++; if (o.stall !== 3 || o.errAtReady !== 1'b0 || o.rdAtReady !== expRead) begin errors++; $display("FAIL to_next: stall=%0d err=%b rdata=%h want 3,0,%h", o.stall, o.errAtReady, o.rdAtReady, expRead); end
    endtask

    task automatic test_ack_at_timeout();
        obs_t o;
        run_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, TO - 1, 32'h0BAD_CAFE, o);
        go_idle();
        expRead = 32'h0BAD_CAFE;
        checks++; if (o.errAtReady !== 1'b0 || o.rdAtReady !== expRead || o.stall !== TO + 1) begin errors++; $display("FAIL ack_wins: err=%b rdata=%h stall=%0d want 0,%h,%0d", o.errAtReady, o.rdAtReady, o.stall, expRead, TO + 1); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1; MemReadM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h0000_0500; mem_ack = 1'b0; #1;
        checks++; if (MemReady !== 1'b0) begin errors++; $display("FAIL rmid_start: ready=%b want 0", MemReady); end
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1; #1;
        checks++; if (MemReady !== 1'b1 || MemErr !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL rmid_during: ready=%b err=%b req=%b want 1,0,1", MemReady, MemErr, mem_req); end
        @(posedge clk); #1; rst = 1'b0; MemReadM = 1'b0; ALUOutM = 32'h0; #1;
        expRead = 32'h0;
        checks++; if (mem_req !== 1'b0 || MemReady !== 1'b1 || ReadDataM !== 32'h0) begin errors++; $display("FAIL rmid_after: req=%b ready=%b rdata=%h want 0,1,0", mem_req, MemReady, ReadDataM); end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            checks++; if (mem_req !== 1'b0 || MemReady !== 1'b1 || ReadDataM !== expRead) begin errors++; $display("FAIL rmid_late_ack: req=%b ready=%b rdata=%h want 0,1,%h", mem_req, MemReady, ReadDataM, expRead); end
        end
        mem_ack = 1'b0;
    endtask

    // Random accesses checked against a transaction-level model of stall, fault and load-data results.
    task automatic test_random();
        obs_t o;
        logic rd, wr;
        logic [31:0] addr, wdata, rdata, expAddr;
        int op, waits, eStall, eReq;
        logic eErr, aligned;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            rd = (op != 1); wr = (op != 0);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            waits = ($urandom_range(0, 4) == 0) ? 1000 : $urandom_range(0, TO - 1);
            wdata = $urandom; rdata = $urandom;
            aligned = (addr[1:0] == 2'b00);
            expAddr = addr & 32'hFFFF_FFFC;
            if (!aligned) begin
                eStall = 0; eReq = 0; eErr = 1'b1;
            end else if (waits < TO) begin
                eStall = waits + 2; eReq = waits + 1; eErr = 1'b0;
                if (!wr) expRead = rdata;
            end else begin
                eStall = TO + 1; eReq = TO; eErr = 1'b1;
                if (!wr) expRead = 32'h0;
            end
            run_access(rd, wr, addr, wdata, waits, rdata, o);
            checks++; if (o.hung !== 1'b0 || o.stall !== eStall || o.reqCycles !== eReq) begin errors++; $display("FAIL rand_timing[%0d]: hung=%b stall=%0d req=%0d want 0,%0d,%0d", i, o.hung, o.stall, o.reqCycles, eStall, eReq); end
            checks++; if (o.errAtReady !== eErr || o.rdAtReady !== expRead) begin errors++; $display("FAIL rand_result[%0d]: err=%b rdata=%h want %b,%h", i, o.errAtReady, o.rdAtReady, eErr, expRead); end
            if (aligned) begin
                checks++; if (o.addrSeen !== expAddr || o.weSeen !== wr || o.stable !== 1'b1 || (wr && o.wdataSeen !== wdata)) begin errors++; $display("FAIL rand_req[%0d]: addr=%h we=%b wdata=%h stable=%b want %h,%b,%h,1", i, o.addrSeen, o.weSeen, o.wdataSeen, o.stable, expAddr, wr, wdata); end
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
